ifu_mem_arbiter: RTL and testbench

// - Shares the single instruction-side memory port between the fetch path (including the
//   two-beat spill sequence) and the hardware page-table walker.
// - Sits between the IFU spill logic / HPTW and the I$/bus interface.
// - Registers the winning address and guarantees that both halves of a spill are issued

---
 rtl/ifu_mem_arbiter.sv | 105 ++++++++++
 tb/tb_ifu_mem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ifu_mem_arbiter.sv
// Arbitrates the single instruction-side memory port between fetch (incl. two-beat spills)
// and the hardware page-table walker, with spill atomicity and a fetch starvation bound.
module ifu_mem_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            FetchReq,
    input  logic [XLEN-1:0] FetchAdr,
    input  logic            FetchSpill,
    input  logic            FetchFlush,
    input  logic            WalkReq,
    input  logic [XLEN-1:0] WalkAdr,
    input  logic            MemAck,
    output logic            MemReq,
    output logic [XLEN-1:0] MemAdr,
    output logic            MemSrcWalk,
    output logic            FetchAck,
    output logic            WalkAck,
    output logic            FetchStall,
    output logic            WalkStall
);

    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_W = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t            state, state_next;
    logic              spill_lock, spill_lock_next;
    logic [AGE_W-1:0]  age_cnt, age_next;
    logic [XLEN-1:0]   adr_next;
    logic              arb, fetch_elig, starved, grant_fetch, grant_walk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            spill_lock <= 1'b0;
            age_cnt    <= '0;
            MemAdr     <= '0;
        end else begin
            state      <= state_next;
            spill_lock <= spill_lock_next;
            age_cnt    <= age_next;
            MemAdr     <= adr_next;
        end
    end

    always_comb begin
        fetch_elig  = FetchReq & ~FetchFlush;
        starved     = (age_cnt == AGE_W'(STARVE_LIMIT));
        // Every state with an access in flight re-arbitrates on its ack, so no idle bubble.
        arb         = (state == IDLE) | MemAck;
        grant_fetch = 1'b0;
        grant_walk  = 1'b0;
        if (arb) begin
            if (spill_lock) begin
                grant_fetch = fetch_elig;
            end else if (starved && fetch_elig) begin
                grant_fetch = 1'b1;
            end else if (WalkReq) begin
                grant_walk = 1'b1;
            end else begin
                grant_fetch = fetch_elig;
            end
        end

        state_next = state;
        if (arb) begin
            if (grant_walk)       state_next = BUSY_W;
            else if (grant_fetch) state_next = BUSY_F;
            else                  state_next = IDLE;
        end else if (state == BUSY_F && FetchFlush) begin
            state_next = DRAIN;
        end

        adr_next = MemAdr;
        if (grant_walk)  adr_next = WalkAdr;
        if (grant_fetch) adr_next = FetchAdr;

        spill_lock_next = spill_lock;
        if (FetchFlush)  spill_lock_next = 1'b0;
        if (grant_fetch) spill_lock_next = FetchSpill;

        age_next = age_cnt;
        if (!FetchReq || grant_fetch) begin
            age_next = '0;
        end else if (grant_walk && fetch_elig && !starved) begin
            age_next = age_cnt + AGE_W'(1);
        end

        MemReq     = (state != IDLE);
        MemSrcWalk = (state == BUSY_W);
        FetchAck   = MemAck & (state == BUSY_F) & ~FetchFlush;
        WalkAck    = MemAck & (state == BUSY_W);
        FetchStall = FetchReq & ~FetchAck;
        WalkStall  = WalkReq & ~WalkAck;
    end

endmodule

// File: tb/tb_ifu_mem_arbiter.sv
// Directed bench for ifu_mem_arbiter: lone fetch, walker priority, spill atomicity,
// starvation bound, flush/drain and asynchronous reset.
module tb_ifu_mem_arbiter;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            FetchReq, FetchSpill, FetchFlush, WalkReq, MemAck;
    logic [XLEN-1:0] FetchAdr, WalkAdr;
    logic            MemReq, MemSrcWalk, FetchAck, WalkAck, FetchStall, WalkStall;
    logic [XLEN-1:0] MemAdr;

    int checks = 0;
    int errors = 0;

    ifu_mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .FetchReq   (FetchReq),
        .FetchAdr   (FetchAdr),
        .FetchSpill (FetchSpill),
        .FetchFlush (FetchFlush),
        .WalkReq    (WalkReq),
        .WalkAdr    (WalkAdr),
        .MemAck     (MemAck),
        .MemReq     (MemReq),
        .MemAdr     (MemAdr),
        .MemSrcWalk (MemSrcWalk),
        .FetchAck   (FetchAck),
        .WalkAck    (WalkAck),
        .FetchStall (FetchStall),
        .WalkStall  (WalkStall)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        FetchReq = 1'b0; FetchSpill = 1'b0; FetchFlush = 1'b0;
        WalkReq = 1'b0; MemAck = 1'b0;
        FetchAdr = '0; WalkAdr = '0;

        // Reset values
        #3;
        check_eq("rst_memreq", 64'(MemReq), 64'd0);
        check_eq("rst_memadr", MemAdr, 64'd0);
        check_eq("rst_srcwalk", 64'(MemSrcWalk), 64'd0);
        check_eq("rst_state", 64'(dut.state), 64'd0);
        FetchReq = 1'b1; WalkReq = 1'b1; MemAck = 1'b1;
        #1;
        check_eq("rst_fetchstall", 64'(FetchStall), 64'd1);
        check_eq("rst_walkstall", 64'(WalkStall), 64'd1);
        check_eq("rst_acks", 64'({FetchAck, WalkAck}), 64'd0);
        FetchReq = 1'b0; WalkReq = 1'b0; MemAck = 1'b0;
        step();
        reset = 1'b1;

        // Lone fetch, ack in the third busy cycle
        FetchReq = 1'b1; FetchAdr = 64'h8000_0000;
        #1;
        check_eq("t1_memreq_t0", 64'(MemReq), 64'd0);
        check_eq("t1_stall_t0", 64'(FetchStall), 64'd1);
        step();
        check_eq("t1_memreq_t1", 64'(MemReq), 64'd1);
        check_eq("t1_memadr", MemAdr, 64'h8000_0000);
        check_eq("t1_srcwalk", 64'(MemSrcWalk), 64'd0);
        check_eq("t1_noack", 64'(FetchAck), 64'd0);
        step();
        step();
        MemAck = 1'b1; FetchReq = 1'b0;
        #1;
        check_eq("t1_fetchack", 64'(FetchAck), 64'd1);
        check_eq("t1_walkack", 64'(WalkAck), 64'd0);
        step();
        MemAck = 1'b0;
        check_eq("t1_idle_after", 64'(MemReq), 64'd0);
        MemAck = 1'b1;
        #1;
        check_eq("t1_idle_ack_ignored", 64'({FetchAck, WalkAck}), 64'd0);
        step();
        MemAck = 1'b0;
        check_eq("t1_still_idle", 64'(MemReq), 64'd0);

        // Simultaneous requests: walker first, fetch follows with no gap
        FetchReq = 1'b1; FetchAdr = 64'h1000; WalkReq = 1'b1; WalkAdr = 64'h2000;
        step();
        check_eq("t2_srcwalk", 64'(MemSrcWalk), 64'd1);
        check_eq("t2_memadr_w", MemAdr, 64'h2000);
        check_eq("t2_age1", 64'(dut.age_cnt), 64'd1);
        check_eq("t2_fetchstall", 64'(FetchStall), 64'd1);
        MemAck = 1'b1; WalkReq = 1'b0;
        #1;
        check_eq("t2_walkack", 64'(WalkAck), 64'd1);
        check_eq("t2_fetchack0", 64'(FetchAck), 64'd0);
        step();
        MemAck = 1'b0;
        check_eq("t2_memreq_nogap", 64'(MemReq), 64'd1);
        check_eq("t2_src_fetch", 64'(MemSrcWalk), 64'd0);
        check_eq("t2_memadr_f", MemAdr, 64'h1000);
        check_eq("t2_age0", 64'(dut.age_cnt), 64'd0);
        MemAck = 1'b1; FetchReq = 1'b0;
        #1;
        check_eq("t2_fetchack", 64'(FetchAck), 64'd1);
        step();
        MemAck = 1'b0;
        check_eq("t2_idle", 64'(MemReq), 64'd0);

        // Spill: second half must beat a walker raised during the first half
        FetchReq = 1'b1; FetchSpill = 1'b1; FetchAdr = 64'h8000_003E;
        step();
        check_eq("t3_memadr_h1", MemAdr, 64'h8000_003E);
        check_eq("t3_lock_set", 64'(dut.spill_lock), 64'd1);
        WalkReq = 1'b1; WalkAdr = 64'h3000;
        step();
        check_eq("t3_src_h1", 64'(MemSrcWalk), 64'd0);
        MemAck = 1'b1; FetchAdr = 64'h8000_0040; FetchSpill = 1'b0;
        #1;
        check_eq("t3_ack_h1", 64'(FetchAck), 64'd1);
        step();
        MemAck = 1'b0;
        check_eq("t3_src_h2", 64'(MemSrcWalk), 64'd0);
        check_eq("t3_memadr_h2", MemAdr, 64'h8000_0040);
        check_eq("t3_lock_clr", 64'(dut.spill_lock), 64'd0);
        MemAck = 1'b1; FetchReq = 1'b0;
        #1;
        check_eq("t3_ack_h2", 64'(FetchAck), 64'd1);
        step();
        MemAck = 1'b0;
        check_eq("t3_walk_after", 64'(MemSrcWalk), 64'd1);
        check_eq("t3_memadr_w", MemAdr, 64'h3000);
        MemAck = 1'b1; WalkReq = 1'b0;
        #1;
        check_eq("t3_walkack", 64'(WalkAck), 64'd1);
        step();
        MemAck = 1'b0;
        check_eq("t3_idle", 64'(MemReq), 64'd0);

        // Starvation bound: fetch wins at the 9th arbitration point
        FetchReq = 1'b1; FetchAdr = 64'h5000; WalkReq = 1'b1; WalkAdr = 64'h6000;
        step();
        check_eq("t4_age_1", 64'(dut.age_cnt), 64'd1);
        for (int k = 2; k <= 8; k++) begin
            MemAck = 1'b1;
            step();
            MemAck = 1'b0;
            check_eq($sformatf("t4_age_%0d", k), 64'(dut.age_cnt), 64'(k));
            check_eq($sformatf("t4_src_%0d", k), 64'(MemSrcWalk), 64'd1);
        end
        MemAck = 1'b1;
        step();
        MemAck = 1'b0;
        check_eq("t4_fetch_wins", 64'(MemSrcWalk), 64'd0);
        check_eq("t4_memadr", MemAdr, 64'h5000);
        check_eq("t4_age_clr", 64'(dut.age_cnt), 64'd0);
        MemAck = 1'b1; FetchReq = 1'b0; WalkReq = 1'b0;
        step();
        MemAck = 1'b0;
        check_eq("t4_idle", 64'(MemReq), 64'd0);

        // Flush one cycle into BUSY_F, ack two cycles later, walker pending
        FetchReq = 1'b1; FetchAdr = 64'h7000;
        step();
        check_eq("t5_busy_f", 64'(dut.state), 64'd1);
        FetchFlush = 1'b1; WalkReq = 1'b1; WalkAdr = 64'h9000;
        #1;
        check_eq("t5_flush_noack", 64'(FetchAck), 64'd0);
        step();
        FetchFlush = 1'b0; FetchAdr = 64'h7100;
        check_eq("t5_drain", 64'(dut.state), 64'd3);
        check_eq("t5_drain_memreq", 64'(MemReq), 64'd1);
        check_eq("t5_drain_src", 64'(MemSrcWalk), 64'd0);
        step();
        check_eq("t5_drain_hold", 64'(dut.state), 64'd3);
        MemAck = 1'b1;
        #1;
        check_eq("t5_swallow", 64'(FetchAck), 64'd0);
        check_eq("t5_no_walkack", 64'(WalkAck), 64'd0);
        step();
        MemAck = 1'b0;
        check_eq("t5_walk_granted", 64'(MemSrcWalk), 64'd1);
        check_eq("t5_memadr_w", MemAdr, 64'h9000);
        check_eq("t5_age1", 64'(dut.age_cnt), 64'd1);

        // Asynchronous reset mid BUSY_W, checked before the next clock edge
        #2;
        reset = 1'b0;
        #1;
        check_eq("t6_memreq", 64'(MemReq), 64'd0);
        check_eq("t6_state", 64'(dut.state), 64'd0);
        check_eq("t6_srcwalk", 64'(MemSrcWalk), 64'd0);
        check_eq("t6_memadr", MemAdr, 64'd0);
        check_eq("t6_lock", 64'(dut.spill_lock), 64'd0);
        check_eq("t6_age", 64'(dut.age_cnt), 64'd0);
        check_eq("t6_fetchstall", 64'(FetchStall), 64'd1);
        step();
        FetchReq = 1'b0; WalkReq = 1'b0;
        reset = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
